hazard_ctrl: RTL and testbench
==============================

Name: hazard_ctrl

Overview:
- Pipeline hazard and sequencing controller for the 5-stage core (IF, ID, EX, MEM, WB).
- Decodes the instruction currently in ID and tracks a shadow scoreboard of in-flight destination registers.
- Drives the IF/ID stall, the ID/EX bubble and the wrong-path flush.
- Sequences HALT: drain the pipe, then freeze.

Parameters:
- FLUSH_CYCLES, 2, number of cycles ID is killed after a taken branch/JR resolves in EX (legal range 1..3).
- CNT_W, 10, width of the performance counters.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous active-low reset.
- id_inst  in  32  instruction currently in ID (opcode [31:26], rs [25:21], rt [20:16], rd [15:11]).
- branch_taken_f_ex  in  1  branch/JR in EX resolved taken this cycle.
- pc_stall_2_if  out  1  hold PC.
- ifid_stall_2_if  out  1  hold IF/ID register.
- bubble_2_ex  out  1  ID/EX register loads NOP (opcode 6'h3F, all controls 0).
- flush_2_id  out  1  kill the instruction in ID (IF/ID loads NOP).
- halted  out  1  core frozen.
- stall_cnt  out  CNT_W  hazard-bubble cycles.
- flush_cnt  out  CNT_W  taken-branch flush events.

Behaviour:
- Opcode classes:
  - Sources rs+rt: R-type 0,2,4,6,8,10; STW 13; BEQ 15.
  - Source rs only: I-type 1,3,5,7,9,11; LDW 12; BZ 14; JR 16.
  - No sources: HALT 17, NOP 63, all others.
- Destination classes:
  - rd for R-type.
  - rt for I-type and LDW.
  - No destination otherwise.
  - Register 0 is never a hazard, as source or destination.
- Scoreboard: 3 slots (EX, MEM, WB), each {valid, dest[4:0], is_load}; shifts every cycle while not HALTED.
  - EX slot loads the ID instruction's dest when ID advances.
  - EX slot loads invalid on a bubble or flush.
- Hazard: an ID source equals a valid slot dest.
  - Default build: match against EX, MEM or WB. The register file is flopped, so a WB write is not visible in the same cycle. Worst case is 3 stall cycles.
- Stall cycle outputs: pc_stall_2_if=1, ifid_stall_2_if=1, bubble_2_ex=1, stall_cnt+1.
- stall_cnt and flush_cnt saturate at all-ones and never wrap.
- FSM states: RUN, FLUSH, DRAIN, HALTED. Reset state is RUN.
- RUN:
  - branch_taken_f_ex=1: flush_2_id=1 and bubble_2_ex=1; flush_cnt+1. Go to FLUSH with a remaining count of FLUSH_CYCLES-1; if FLUSH_CYCLES=1, stay in RUN. Flush overrides any hazard stall in the same cycle, and no stall is counted.
  - Else, hazard: stall as above.
  - Else, HALT in ID: HALT advances to EX, then go to DRAIN.
- FLUSH:
  - flush_2_id=1 and bubble_2_ex=1; decrement the count; return to RUN at 0.
  - HALT or hazards seen in ID are ignored (wrong path).
  - A new branch_taken_f_ex reloads the count and increments flush_cnt.
- DRAIN:
  - pc_stall_2_if=1, ifid_stall_2_if=1, bubble_2_ex=1.
  - Go to HALTED when all scoreboard slots are invalid and the HALT has left WB. This takes 3 cycles after DRAIN entry.
  - branch_taken_f_ex=1 in the first DRAIN cycle (an older branch in EX) means HALT was wrong-path: perform a normal flush and go to FLUSH.
- HALTED: halted=1; pc_stall, ifid_stall and bubble held at 1; counters frozen. Exit only by reset.
- Reset, asynchronous, any state:
  - State goes to RUN, all slots invalid, counters 0.
  - All outputs 0, except pc_stall/ifid_stall/bubble/flush, which are 0 after reset deasserts.
- All control outputs are combinational from the current state, id_inst, the scoreboard and branch_taken_f_ex.
- Counters and state are registered.

Optional Feature:
- Macro: HAZ_FWD_EN.
- Defined:
  - EX/MEM/WB forwarding exists.
  - A hazard exists only when the EX slot is a valid load (is_load=1) whose dest matches an ID source.
  - Exactly 1 bubble per load-use.
  - MEM/WB matches never stall.
- Undefined: full RAW stall as above.

Decomposition:
- Shared package / struct.sv:
  - Opcode constants (OP_ADD..OP_HALT, OP_NOP=6'h3F).
  - Scoreboard slot struct.
  - FSM state enum.
  - Source/dest class decode function (reusable by id).
- One sub-module: hazard_scoreboard. It holds the 3-slot shift register and the match logic, and outputs hazard.
- FSM, counters and output muxing stay in hazard_ctrl.

Test Plan:
- ADD r3,r1,r2 then ADD r4,r3,r5, default build -> 3 consecutive bubble_2_ex cycles, stall_cnt=3. With HAZ_FWD_EN -> no stall, stall_cnt=0.
- LDW r7,0(r1) then ADDI r8,r7,4 with HAZ_FWD_EN -> exactly 1 bubble, pc_stall_2_if high 1 cycle.
- ADD r0,r1,r2 then ADD r4,r0,r0 -> no stall (r0 exempt).
- branch_taken_f_ex pulse while a RAW hazard is in ID -> flush_2_id high 2 cycles, stall_cnt unchanged, flush_cnt=1.
- HALT in ID following ADD r3,... -> DRAIN 3 cycles, then halted=1 permanently. BEQ taken in EX with HALT in ID -> no halt, FLUSH entered.
- Assert reset mid-DRAIN -> all outputs 0, counters 0, RUN after release. Also run 1100 back-to-back hazards -> stall_cnt saturates at 1023.

Source files
------------

// File: rtl/hazard_ctrl_pkg.sv
// Shared types for the hazard controller: opcodes, ID decode,
// scoreboard slot and FSM state.
package hazard_ctrl_pkg;

    localparam logic [5:0] OP_ADD  = 6'd0;
    localparam logic [5:0] OP_ADDI = 6'd1;
    localparam logic [5:0] OP_SUB  = 6'd2;
    localparam logic [5:0] OP_SUBI = 6'd3;
    localparam logic [5:0] OP_AND  = 6'd4;
    localparam logic [5:0] OP_ANDI = 6'd5;
    localparam logic [5:0] OP_OR   = 6'd6;
    localparam logic [5:0] OP_ORI  = 6'd7;
    localparam logic [5:0] OP_XOR  = 6'd8;
    localparam logic [5:0] OP_XORI = 6'd9;
    localparam logic [5:0] OP_SLT  = 6'd10;
    localparam logic [5:0] OP_SLTI = 6'd11;
    localparam logic [5:0] OP_LDW  = 6'd12;
    localparam logic [5:0] OP_STW  = 6'd13;
    localparam logic [5:0] OP_BZ   = 6'd14;
    localparam logic [5:0] OP_BEQ  = 6'd15;
    localparam logic [5:0] OP_JR   = 6'd16;
    localparam logic [5:0] OP_HALT = 6'd17;
    localparam logic [5:0] OP_NOP  = 6'h3F;

    typedef struct packed {
        logic       valid;
        logic [4:0] dest;
        logic       is_load;
    } sb_slot_t;

    typedef enum logic [1:0] {
        ST_RUN,
        ST_FLUSH,
        ST_DRAIN,
        ST_HALTED
    } hz_state_t;

    typedef struct packed {
        logic       use_rs;
        logic [4:0] rs;
        logic       use_rt;
        logic [4:0] rt;
        logic       has_dst;
        logic [4:0] dst;
        logic       is_load;
        logic       is_halt;
    } id_dec_t;

    // r0 is masked out so it never shows up as a source or dest.
    function automatic id_dec_t decode_id(
        input logic [31:0] inst
    );
        id_dec_t    d;
        logic [5:0] op;
        logic       r_ty;
        logic       i_ty;
        op   = inst[31:26];
        r_ty = op inside {OP_ADD, OP_SUB, OP_AND,
                          OP_OR, OP_XOR, OP_SLT};
        i_ty = op inside {OP_ADDI, OP_SUBI, OP_ANDI,
                          OP_ORI, OP_XORI, OP_SLTI};
        d    = '0;
        d.rs = inst[25:21];
        d.rt = inst[20:16];
        unique case (1'b1)
            r_ty: begin
                d.use_rs  = 1'b1;
                d.use_rt  = 1'b1;
                d.has_dst = 1'b1;
                d.dst     = inst[15:11];
            end
            i_ty: begin
                d.use_rs  = 1'b1;
                d.has_dst = 1'b1;
                d.dst     = inst[20:16];
            end
            (op == OP_LDW): begin
                d.use_rs  = 1'b1;
                d.has_dst = 1'b1;
                d.dst     = inst[20:16];
                d.is_load = 1'b1;
            end
            (op == OP_STW), (op == OP_BEQ): begin
                d.use_rs = 1'b1;
                d.use_rt = 1'b1;
            end
            (op == OP_BZ), (op == OP_JR): begin
                d.use_rs = 1'b1;
            end
            (op == OP_HALT): begin
                d.is_halt = 1'b1;
            end
            default: ;
        endcase
        d.use_rs  = d.use_rs  && (d.rs  != 5'd0);
        d.use_rt  = d.use_rt  && (d.rt  != 5'd0);
        d.has_dst = d.has_dst && (d.dst != 5'd0);
        return d;
    endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// ID-side bundle of the hazard controller: instruction and branch
// resolve in, stall/bubble/flush/halt controls and counters out.
interface hazard_ctrl_if #(
    parameter int CNT_W = 10
);
    logic [31:0]      id_inst;
    logic             branch_taken_f_ex;
    logic             pc_stall_2_if;
    logic             ifid_stall_2_if;
    logic             bubble_2_ex;
    logic             flush_2_id;
    logic             halted;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    modport master (
        output id_inst,
        output branch_taken_f_ex,
        input  pc_stall_2_if,
        input  ifid_stall_2_if,
        input  bubble_2_ex,
        input  flush_2_id,
        input  halted,
        input  stall_cnt,
        input  flush_cnt
    );

    modport slave (
        input  id_inst,
        input  branch_taken_f_ex,
        output pc_stall_2_if,
        output ifid_stall_2_if,
        output bubble_2_ex,
        output flush_2_id,
        output halted,
        output stall_cnt,
        output flush_cnt
    );

endinterface

// File: rtl/hazard_ctrl_scoreboard.sv
// Shadow scoreboard of in-flight dests (EX, MEM, WB) and RAW match.
// With HAZ_FWD_EN only a load sitting in EX can stall ID.
module hazard_scoreboard
    import hazard_ctrl_pkg::*;
(
    input  logic    clk,
    input  logic    reset,
    input  logic    shift_en,
    input  logic    load_en,
    input  id_dec_t dec,
    output logic    hazard,
    output logic    drained
);

    sb_slot_t ex_q;
    sb_slot_t mem_q;
    sb_slot_t wb_q;
    sb_slot_t ex_d;
    logic     unused_bits;

    function automatic logic src_hit(
        input sb_slot_t s,
        input id_dec_t  d
    );
        return s.valid &&
            ((d.use_rs && (d.rs == s.dest)) ||
             (d.use_rt && (d.rt == s.dest)));
    endfunction

    // Entry for the EX slot: the ID dest if it advances, else a hole.
    always_comb begin
        ex_d = '0;
        if (load_en && dec.has_dst) begin
            ex_d.valid   = 1'b1;
            ex_d.dest    = dec.dst;
            ex_d.is_load = dec.is_load;
        end
    end

    // Advance the in-flight dests one stage per cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ex_q  <= '0;
            mem_q <= '0;
            wb_q  <= '0;
        end else if (shift_en) begin
            ex_q  <= ex_d;
            mem_q <= ex_q;
            wb_q  <= mem_q;
        end
    end

`ifdef HAZ_FWD_EN
    assign hazard = ex_q.is_load && src_hit(ex_q, dec);
    assign unused_bits = ^{mem_q.dest, mem_q.is_load,
                           wb_q, dec.is_halt};
`else
    // Regfile write is flopped, so WB still has to be matched.
    assign hazard = src_hit(ex_q, dec) ||
                    src_hit(mem_q, dec) ||
                    src_hit(wb_q, dec);
    assign unused_bits = ^{ex_q.is_load, mem_q.is_load,
                           wb_q.is_load, dec.is_halt};
`endif

    // WB drops out on the next shift, so only EX/MEM matter.
    assign drained = !ex_q.valid && !mem_q.valid;

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard/sequencing controller: RAW stall, branch flush, HALT drain.
// Optional macro HAZ_FWD_EN: forwarding build, load-use stall only.
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int FLUSH_CYCLES = 2,
    parameter int CNT_W        = 10
) (
    input logic         clk,
    input logic         reset,
    hazard_ctrl_if.slave bus
);

    localparam logic [1:0] FLUSH_LOAD =
        2'(FLUSH_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    hz_state_t        state_q;
    logic [1:0]       flush_left_q;
    logic [1:0]       drain_cnt_q;
    logic [CNT_W-1:0] stall_cnt_q;
    logic [CNT_W-1:0] flush_cnt_q;

    id_dec_t dec;
    logic    hazard;
    logic    drained;
    logic    take_flush;
    logic    do_stall;
    logic    hold;
    logic    bubble;
    logic    branch_hit;

    function automatic logic [CNT_W-1:0] sat_inc(
        input logic [CNT_W-1:0] v
    );
        return (v == CNT_MAX) ? v : v + CNT_W'(1);
    endfunction

    assign dec = decode_id(bus.id_inst);

    hazard_scoreboard u_sb (
        .clk      (clk),
        .reset    (reset),
        .shift_en (state_q != ST_HALTED),
        .load_en  (!bubble),
        .dec      (dec),
        .hazard   (hazard),
        .drained  (drained)
    );

    // Pick this cycle's action; a taken branch beats any stall.
    always_comb begin
        take_flush = 1'b0;
        do_stall   = 1'b0;
        hold       = 1'b0;
        unique case (state_q)
            ST_RUN: begin
                if (bus.branch_taken_f_ex) begin
                    take_flush = 1'b1;
                end else if (hazard) begin
                    do_stall = 1'b1;
                end
            end
            ST_FLUSH: begin
                take_flush = 1'b1;
            end
            ST_DRAIN: begin
                if (bus.branch_taken_f_ex &&
                    (drain_cnt_q == 2'd0)) begin
                    take_flush = 1'b1;
                end else begin
                    hold = 1'b1;
                end
            end
            ST_HALTED: begin
                hold = 1'b1;
            end
            default: ;
        endcase
    end

    assign bubble     = do_stall || hold || take_flush;
    assign branch_hit = take_flush && bus.branch_taken_f_ex;

    assign bus.pc_stall_2_if   = do_stall || hold;
    assign bus.ifid_stall_2_if = do_stall || hold;
    assign bus.bubble_2_ex     = bubble;
    assign bus.flush_2_id      = take_flush;
    assign bus.halted          = (state_q == ST_HALTED);
    assign bus.stall_cnt       = stall_cnt_q;
    assign bus.flush_cnt       = flush_cnt_q;

    // Sequencer state, flush/drain counts and perf counters.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_RUN;
            flush_left_q <= 2'd0;
            drain_cnt_q  <= 2'd0;
            stall_cnt_q  <= '0;
            flush_cnt_q  <= '0;
        end else if (state_q != ST_HALTED) begin
            if (branch_hit) begin
                flush_cnt_q  <= sat_inc(flush_cnt_q);
                flush_left_q <= FLUSH_LOAD;
                state_q      <= (FLUSH_CYCLES > 1) ?
                                ST_FLUSH : ST_RUN;
            end else begin
                unique case (state_q)
                    ST_RUN: begin
                        if (do_stall) begin
                            stall_cnt_q <= sat_inc(stall_cnt_q);
                        end else if (dec.is_halt) begin
                            state_q     <= ST_DRAIN;
                            drain_cnt_q <= 2'd0;
                        end
                    end
                    ST_FLUSH: begin
                        flush_left_q <= flush_left_q - 2'd1;
                        if (flush_left_q <= 2'd1) begin
                            state_q <= ST_RUN;
                        end
                    end
                    ST_DRAIN: begin
                        if ((drain_cnt_q == 2'd2) && drained) begin
                            state_q <= ST_HALTED;
                        end else if (drain_cnt_q != 2'd3) begin
                            drain_cnt_q <= drain_cnt_q + 2'd1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: vector table for RAW/flush traces,
// hand sequences for HALT drain, reset mid-drain and saturation.
module tb_hazard_ctrl;
    import hazard_ctrl_pkg::*;

    localparam int CNT_W = 10;
`ifdef HAZ_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    typedef struct packed {
        logic [31:0] inst;
        logic        bt;
        logic        s_def;
        logic        s_fwd;
        logic        fl;
    } vec_t;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   fails  = 0;
    int   exp_stall = 0;
    int   exp_flush = 0;
    vec_t vt[$];

    always #5 clk = ~clk;

    hazard_ctrl_if #(.CNT_W(CNT_W)) bus ();

    hazard_ctrl #(
        .FLUSH_CYCLES (2),
        .CNT_W        (CNT_W)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    function automatic logic [31:0] rt3(
        input logic [5:0] op, input logic [4:0] rs,
        input logic [4:0] rt, input logic [4:0] rd
    );
        return {op, rs, rt, rd, 11'd0};
    endfunction

    function automatic logic [31:0] it(
        input logic [5:0] op, input logic [4:0] rs,
        input logic [4:0] rt, input logic [15:0] imm
    );
        return {op, rs, rt, imm};
    endfunction

    function automatic vec_t mk(
        input logic [31:0] inst, input logic bt,
        input logic s_def, input logic s_fwd, input logic fl
    );
        vec_t v;
        v.inst  = inst;
        v.bt    = bt;
        v.s_def = s_def;
        v.s_fwd = s_fwd;
        v.fl    = fl;
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply(input logic [31:0] inst, input logic bt);
        bus.id_inst           = inst;
        bus.branch_taken_f_ex = bt;
        #3;
    endtask

    task automatic chk(input string name, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%0d exp=%0d", name, got, exp);
        end
    endtask

    // Order: {pc_stall, ifid_stall, bubble, flush, halted}
    task automatic chk_out(input string name, input logic [4:0] exp);
        logic [4:0] got;
        got = {bus.pc_stall_2_if, bus.ifid_stall_2_if,
               bus.bubble_2_ex, bus.flush_2_id, bus.halted};
        checks++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s outs got=%b exp=%b", name, got, exp);
        end
    endtask

    task automatic do_reset();
        reset = 1'b0;
        tick();
        reset = 1'b1;
    endtask

    logic [31:0] nop_i, halt_i, add3, add4, add_r0, add_rr0;
    logic [31:0] ldw7, addi8, ldw3;
    logic        s;

    initial begin
        nop_i   = {OP_NOP, 26'd0};
        halt_i  = {OP_HALT, 26'd0};
        add3    = rt3(OP_ADD, 5'd1, 5'd2, 5'd3);
        add4    = rt3(OP_ADD, 5'd3, 5'd5, 5'd4);
        add_r0  = rt3(OP_ADD, 5'd1, 5'd2, 5'd0);
        add_rr0 = rt3(OP_ADD, 5'd0, 5'd0, 5'd4);
        ldw7    = it(OP_LDW, 5'd1, 5'd7, 16'd0);
        addi8   = it(OP_ADDI, 5'd7, 5'd8, 16'd4);
        ldw3    = it(OP_LDW, 5'd3, 5'd3, 16'd0);

        // RAW on r3: 3 stalls, none with forwarding
        vt.push_back(mk(add3, 0, 0, 0, 0));
        vt.push_back(mk(add4, 0, 1, 0, 0));
        vt.push_back(mk(add4, 0, 1, 0, 0));
        vt.push_back(mk(add4, 0, 1, 0, 0));
        vt.push_back(mk(add4, 0, 0, 0, 0));
        repeat (3) vt.push_back(mk(nop_i, 0, 0, 0, 0));
        // r0 is never a hazard
        vt.push_back(mk(add_r0, 0, 0, 0, 0));
        vt.push_back(mk(add_rr0, 0, 0, 0, 0));
        repeat (3) vt.push_back(mk(nop_i, 0, 0, 0, 0));
        // load-use: 3 stalls, or 1 with forwarding
        vt.push_back(mk(ldw7, 0, 0, 0, 0));
        vt.push_back(mk(addi8, 0, 1, 1, 0));
        vt.push_back(mk(addi8, 0, 1, 0, 0));
        vt.push_back(mk(addi8, 0, 1, 0, 0));
        vt.push_back(mk(addi8, 0, 0, 0, 0));
        repeat (3) vt.push_back(mk(nop_i, 0, 0, 0, 0));
        // branch overrides hazard, FLUSH ignores wrong-path hazard
        vt.push_back(mk(add3, 0, 0, 0, 0));
        vt.push_back(mk(add4, 1, 0, 0, 1));
        vt.push_back(mk(add4, 0, 0, 0, 1));
        vt.push_back(mk(nop_i, 0, 0, 0, 0));
        // new branch during FLUSH reloads the count
        vt.push_back(mk(nop_i, 1, 0, 0, 1));
        vt.push_back(mk(nop_i, 1, 0, 0, 1));
        vt.push_back(mk(nop_i, 0, 0, 0, 1));
        repeat (3) vt.push_back(mk(nop_i, 0, 0, 0, 0));

        reset = 1'b0;
        apply(nop_i, 1'b0);
        chk_out("reset_outs", 5'b00000);
        chk("reset_stall_cnt", 32'(bus.stall_cnt), 32'd0);
        chk("reset_flush_cnt", 32'(bus.flush_cnt), 32'd0);
        tick();
        reset = 1'b1;

        for (int i = 0; i < vt.size(); i++) begin
            s = FWD ? vt[i].s_fwd : vt[i].s_def;
            apply(vt[i].inst, vt[i].bt);
            chk_out($sformatf("vec%0d", i),
                    {s, s, s | vt[i].fl, vt[i].fl, 1'b0});
            chk($sformatf("vec%0d_stall_cnt", i),
                32'(bus.stall_cnt), 32'(exp_stall));
            chk($sformatf("vec%0d_flush_cnt", i),
                32'(bus.flush_cnt), 32'(exp_flush));
            if (s) exp_stall++;
            if (vt[i].bt) exp_flush++;
            tick();
        end
        chk("trace_stall_total", 32'(bus.stall_cnt),
            FWD ? 32'd1 : 32'd6);
        chk("trace_flush_total", 32'(bus.flush_cnt), 32'd3);

        // HALT after ADD: 3 drain cycles then frozen for good
        apply(add3, 1'b0);
        chk_out("halt_pre", 5'b00000);
        tick();
        apply(halt_i, 1'b0);
        chk_out("halt_in_id", 5'b00000);
        tick();
        for (int i = 0; i < 3; i++) begin
            apply(halt_i, 1'b0);
            chk_out($sformatf("drain%0d", i), 5'b11100);
            tick();
        end
        for (int i = 0; i < 4; i++) begin
            apply(halt_i, 1'b1);
            chk_out($sformatf("halted%0d", i), 5'b11101);
            tick();
        end
        chk("halted_stall_frozen", 32'(bus.stall_cnt),
            32'(exp_stall));
        chk("halted_flush_frozen", 32'(bus.flush_cnt),
            32'(exp_flush));

        // reset asserted mid-DRAIN
        do_reset();
        apply(ldw7, 1'b0);
        tick();
        apply(addi8, 1'b0);
        chk_out("b_stall", 5'b11100);
        tick();
        apply(halt_i, 1'b0);
        chk_out("b_halt_id", 5'b00000);
        tick();
        apply(halt_i, 1'b0);
        chk_out("b_drain", 5'b11100);
        chk("b_stall_cnt", 32'(bus.stall_cnt), 32'd1);
        #2;
        reset = 1'b0;
        bus.id_inst = nop_i;
        #1;
        chk_out("b_rst_outs", 5'b00000);
        chk("b_rst_stall_cnt", 32'(bus.stall_cnt), 32'd0);
        chk("b_rst_flush_cnt", 32'(bus.flush_cnt), 32'd0);
        tick();
        tick();
        reset = 1'b1;
        apply(nop_i, 1'b0);
        chk_out("b_run_nop", 5'b00000);
        tick();
        apply(halt_i, 1'b0);
        chk_out("b_run_halt", 5'b00000);
        tick();

        // taken branch with HALT in ID: flush, never halt
        do_reset();
        apply(halt_i, 1'b1);
        chk_out("c_br_halt", 5'b00110);
        tick();
        apply(halt_i, 1'b0);
        chk_out("c_flush", 5'b00110);
        tick();
        apply(nop_i, 1'b0);
        chk_out("c_run", 5'b00000);
        repeat (4) tick();
        apply(nop_i, 1'b0);
        chk_out("c_nohalt", 5'b00000);
        chk("c_flush_cnt", 32'(bus.flush_cnt), 32'd1);
        tick();

        // older branch in first DRAIN cycle cancels the HALT
        apply(halt_i, 1'b0);
        chk_out("d_halt_id", 5'b00000);
        tick();
        apply(halt_i, 1'b1);
        chk_out("d_drain_br", 5'b00110);
        tick();
        apply(nop_i, 1'b0);
        chk_out("d_flush", 5'b00110);
        tick();
        apply(nop_i, 1'b0);
        chk_out("d_run", 5'b00000);
        repeat (4) tick();
        apply(nop_i, 1'b0);
        chk_out("d_nohalt", 5'b00000);
        chk("d_flush_cnt", 32'(bus.flush_cnt), 32'd2);
        chk("d_stall_cnt", 32'(bus.stall_cnt), 32'd0);

        // back-to-back load-use hazards saturate stall_cnt
        do_reset();
        apply(ldw3, 1'b0);
        repeat (2200) tick();
        apply(ldw3, 1'b0);
        chk("sat_stall_cnt", 32'(bus.stall_cnt), 32'd1023);
        chk("sat_flush_cnt", 32'(bus.flush_cnt), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
